mem_port_sched: RTL and testbench

Shares one single-outstanding memory port among `NUM_REQ` requesters using credit-based weighted round-robin. It runs one complete transaction at a time: accept, issue, optional read-data wait, response. It sits between the requester-side masters (cache-fill, DMA, host) and the memory controller port, and owns arbitration plus request/response routing for that port.

---
 rtl/mem_sched_pkg.sv | 29 ++
 rtl/mem_sched_wrr_pick.sv | 59 +++++
 rtl/mem_port_sched.sv | 144 ++++++++++++++
 tb/tb_mem_port_sched.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sched_pkg.sv
// rtl/mem_sched_pkg.sv - shared types and helpers for the memory port scheduler
//
// Purpose : FSM state encoding and the per-requester weight extraction used
//           by mem_port_sched and mem_sched_wrr_pick.
// Contents: state_t   - IDLE / ISSUE / WAIT_RSP
//           weight_at - pull one WEIGHT_W field out of a packed weight vector,
//                       mapping a zero weight to one
package mem_sched_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RSP = 2'd2
  } state_t;

  // Packed weights are handled as 64-bit values so one function serves every
  // parameterisation; callers slice the low WEIGHT_W bits of the result.
  function automatic logic [63:0] weight_at(input logic [63:0] flat,
                                            input int          idx,
                                            input int          ww);
    logic [63:0] field;
    field = (flat >> (idx * ww)) & ((64'd1 << ww) - 64'd1);
    if (field == 64'd0) begin
      field = 64'd1;
    end
    return field;
  endfunction

endpackage

// File: rtl/mem_sched_wrr_pick.sv
// rtl/mem_sched_wrr_pick.sv - rotate-priority pick with weighted credit update
//
// Purpose : Combinational arbiter. Finds the first valid requester starting
//           at ptr (wrapping), and computes the pointer/credit that apply if
//           that requester is accepted this cycle.
// Ports   : valid       - per-requester request valid
//           ptr, credit - current round-robin pointer and remaining credit
//           weights     - per-requester weights, already mapped 0 -> 1
//           g, any      - selected requester, and whether any was valid
//           next_ptr    - pointer to load on accept
//           next_credit - credit to load on accept
module mem_sched_wrr_pick #(
  parameter int NUM_REQ  = 2,
  parameter int WEIGHT_W = 3,
  parameter int PTR_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid,
  input  logic [PTR_W-1:0]    ptr,
  input  logic [WEIGHT_W-1:0] credit,
  input  logic [WEIGHT_W-1:0] weights [NUM_REQ],
  output logic [PTR_W-1:0]    g,
  output logic                any,
  output logic [PTR_W-1:0]    next_ptr,
  output logic [WEIGHT_W-1:0] next_credit
);

  logic [PTR_W-1:0]    idx;
  logic [WEIGHT_W-1:0] eff;

  // NUM_REQ is a power of two, so ptr + k wraps naturally in PTR_W bits.
  always_comb begin
    g   = '0;
    any = 1'b0;
    idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (!any && valid[idx]) begin
        g   = idx;
        any = 1'b1;
      end
    end
  end

  // The pointed-to requester spends its remaining credit; anyone else that
  // wins (pointer owner idle) starts from its full weight.
  always_comb begin
    eff         = (g == ptr) ? credit : weights[g];
    next_ptr    = g;
    next_credit = eff;
    if (eff > WEIGHT_W'(1)) begin
      next_ptr    = g;
      next_credit = eff - WEIGHT_W'(1);
    end else begin
      next_ptr    = g + PTR_W'(1);
      next_credit = weights[next_ptr];
    end
  end

endmodule

// File: rtl/mem_port_sched.sv
// rtl/mem_port_sched.sv - weighted round-robin sharing of one memory port
//
// Purpose : Arbitrates NUM_REQ requesters onto a single-outstanding memory
//           port, one complete transaction at a time, and routes the
//           write ack / read data back to the owner.
// Ports   : clk_i, rst_i                - clock, async active-high reset
//           req_valid_i/req_ready_o     - per-requester handshake (ready is
//                                         combinational, one-hot, IDLE only)
//           req_we_i/req_addr_i/req_wdata_i - flat per-requester fields
//           rsp_valid_o/rsp_rdata_o     - one-cycle completion pulse + data
//           grant_o                     - one-hot owner of in-flight transfer
//           mem_valid_o/mem_ready_i/mem_we_o/mem_addr_o/mem_wdata_o
//                                       - memory request channel
//           mem_rvalid_i/mem_rdata_i    - memory read-response channel
module mem_port_sched
  import mem_sched_pkg::*;
#(
  parameter int                               NUM_REQ  = 2,
  parameter int                               ADDR_W   = 32,
  parameter int                               DATA_W   = 32,
  parameter int                               WEIGHT_W = 3,
  parameter logic [NUM_REQ*WEIGHT_W-1:0]      WEIGHTS  = 6'h0A
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [NUM_REQ-1:0]          req_we_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [NUM_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]           rsp_rdata_o,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic                        mem_valid_o,
  input  logic                        mem_ready_i,
  output logic                        mem_we_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic                        mem_rvalid_i,
  input  logic [DATA_W-1:0]           mem_rdata_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [63:0] W0_FULL = weight_at(64'(WEIGHTS), 0, WEIGHT_W);
  localparam logic [WEIGHT_W-1:0] CREDIT_RST = W0_FULL[WEIGHT_W-1:0];

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [WEIGHT_W-1:0] credit;

  logic [WEIGHT_W-1:0] weight_tbl [NUM_REQ];
  logic [ADDR_W-1:0]   addr_arr   [NUM_REQ];
  logic [DATA_W-1:0]   wdata_arr  [NUM_REQ];

  logic [PTR_W-1:0]    pick_g;
  logic                pick_any;
  logic [PTR_W-1:0]    pick_next_ptr;
  logic [WEIGHT_W-1:0] pick_next_credit;
  logic [NUM_REQ-1:0]  pick_onehot;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    localparam logic [63:0] W_FULL = weight_at(64'(WEIGHTS), i, WEIGHT_W);
    assign weight_tbl[i] = W_FULL[WEIGHT_W-1:0];
    assign addr_arr[i]   = req_addr_i[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i]  = req_wdata_i[i*DATA_W +: DATA_W];
  end

  mem_sched_wrr_pick #(
    .NUM_REQ  (NUM_REQ),
    .WEIGHT_W (WEIGHT_W),
    .PTR_W    (PTR_W)
  ) u_pick (
    .valid       (req_valid_i),
    .ptr         (ptr),
    .credit      (credit),
    .weights     (weight_tbl),
    .g           (pick_g),
    .any         (pick_any),
    .next_ptr    (pick_next_ptr),
    .next_credit (pick_next_credit)
  );

  assign pick_onehot = NUM_REQ'(1) << pick_g;

  // Accept is implied by valid & ready in IDLE, so ready must not depend on
  // anything registered other than state/ptr/credit.
  assign req_ready_o = ((state == IDLE) && pick_any) ? pick_onehot : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      credit      <= CREDIT_RST;
      grant_o     <= '0;
      rsp_valid_o <= '0;
      rsp_rdata_o <= '0;
      mem_valid_o <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      rsp_valid_o <= '0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            grant_o     <= pick_onehot;
            mem_valid_o <= 1'b1;
            mem_we_o    <= req_we_i[pick_g];
            mem_addr_o  <= addr_arr[pick_g];
            mem_wdata_o <= wdata_arr[pick_g];
            ptr         <= pick_next_ptr;
            credit      <= pick_next_credit;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            if (mem_we_o) begin
              // Writes complete on the request handshake; ack right away.
              rsp_valid_o <= grant_o;
              grant_o     <= '0;
              state       <= IDLE;
            end else begin
              state <= WAIT_RSP;
            end
          end
        end
        WAIT_RSP: begin
          if (mem_rvalid_i) begin
            rsp_rdata_o <= mem_rdata_i;
            rsp_valid_o <= grant_o;
            grant_o     <= '0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_sched.sv
// tb/tb_mem_port_sched.sv - directed table and sequence bench for mem_port_sched
module tb_mem_port_sched;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  logic [1:0]  req_we_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic [1:0]  rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  grant_o;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  mem_port_sched #(
    .NUM_REQ  (2),
    .ADDR_W   (32),
    .DATA_W   (32),
    .WEIGHT_W (3),
    .WEIGHTS  (6'h0A)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .grant_o      (grant_o),
    .mem_valid_o  (mem_valid_o),
    .mem_ready_i  (mem_ready_i),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i)
  );

  typedef struct {
    logic        rst;
    logic [1:0]  valid;
    logic [1:0]  we;
    logic        mrdy;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_grant;
    logic        exp_mv;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] valid,
                              input logic [1:0] ready, input logic [1:0] grant,
                              input logic mv, input logic [1:0] rsp,
                              input logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.valid = valid; v.we = 2'b11; v.mrdy = 1'b1;
    v.exp_ready = ready; v.exp_grant = grant; v.exp_mv = mv;
    v.exp_rsp = rsp; v.exp_addr = addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic mr,
                       input logic mrv, input logic [31:0] rd);
    req_valid_i = v; req_we_i = w; mem_ready_i = mr; mem_rvalid_i = mrv; mem_rdata_i = rd;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    tick();
    rst_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"}, 32'(req_ready_o), 32'h0);
    check({tag, ".grant"}, 32'(grant_o), 32'h0);
    check({tag, ".rsp"},   32'(rsp_valid_o), 32'h0);
    check({tag, ".rdata"}, rsp_rdata_o, 32'h0);
    check({tag, ".mv"},    32'(mem_valid_o), 32'h0);
    check({tag, ".mwe"},   32'(mem_we_o), 32'h0);
    check({tag, ".maddr"}, mem_addr_o, 32'h0);
    check({tag, ".mwdata"}, mem_wdata_o, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_i = 1'b1;
    drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0);
    req_addr_i  = {32'h0000_2000, 32'h0000_1000};
    req_wdata_i = {32'h0000_00B1, 32'h0000_00A0};
    @(negedge clk_i);
    check_all_zero("reset");
    tick();
    rst_i = 1'b0;

    // WRR with w0=2, w1=1, both always writing: order 0,0,1,0,0,1.
    vecs.push_back(mk(0, 2'b11, 2'b01, 2'b00, 0, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 2'b00, 32'h1000));
    vecs.push_back(mk(0, 2'b11, 2'b01, 2'b00, 0, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 2'b00, 32'h1000));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 0, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 1, 2'b00, 32'h2000));
    vecs.push_back(mk(0, 2'b11, 2'b01, 2'b00, 0, 2'b10, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 2'b00, 32'h1000));
    vecs.push_back(mk(0, 2'b11, 2'b01, 2'b00, 0, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 2'b00, 32'h1000));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 0, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b10, 1, 2'b00, 32'h2000));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 32'h0));
    // Reset, then req1 alone: pointer moves to 0 with credit 2, so req0
    // wins the next two accepts even with req1 competing.
    vecs.push_back(mk(1, 2'b00, 2'b00, 2'b00, 0, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b10, 2'b10, 2'b00, 0, 2'b00, 32'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b10, 1, 2'b00, 32'h2000));
    vecs.push_back(mk(0, 2'b11, 2'b01, 2'b00, 0, 2'b10, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 2'b00, 32'h1000));
    vecs.push_back(mk(0, 2'b11, 2'b01, 2'b00, 0, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b11, 2'b00, 2'b01, 1, 2'b00, 32'h1000));
    vecs.push_back(mk(0, 2'b11, 2'b10, 2'b00, 0, 2'b01, 32'h0));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b10, 1, 2'b00, 32'h2000));
    vecs.push_back(mk(0, 2'b00, 2'b00, 2'b00, 0, 2'b10, 32'h0));

    foreach (vecs[n]) begin
      tick();
      rst_i = vecs[n].rst;
      drive(vecs[n].valid, vecs[n].we, vecs[n].mrdy, 1'b0, 32'h0);
      @(negedge clk_i);
      check($sformatf("vec%0d.ready", n), 32'(req_ready_o), 32'(vecs[n].exp_ready));
      check($sformatf("vec%0d.grant", n), 32'(grant_o), 32'(vecs[n].exp_grant));
      check($sformatf("vec%0d.mv", n), 32'(mem_valid_o), 32'(vecs[n].exp_mv));
      check($sformatf("vec%0d.rsp", n), 32'(rsp_valid_o), 32'(vecs[n].exp_rsp));
      if (vecs[n].exp_mv) begin
        check($sformatf("vec%0d.maddr", n), mem_addr_o, vecs[n].exp_addr);
      end
    end

    // Read with latency: rvalid at cycle 4 gives response at cycle 5.
    req_addr_i = {32'h0000_2000, 32'h0000_0100};
    do_reset();
    tick(); drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("rd.c0.ready", 32'(req_ready_o), 32'h1);
    tick(); drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0); @(negedge clk_i);
    check("rd.c1.mv", 32'(mem_valid_o), 32'h1);
    check("rd.c1.maddr", mem_addr_o, 32'h100);
    check("rd.c1.mwe", 32'(mem_we_o), 32'h0);
    check("rd.c1.grant", 32'(grant_o), 32'h1);
    tick(); drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("rd.c2.mv", 32'(mem_valid_o), 32'h0);
    check("rd.c2.grant", 32'(grant_o), 32'h1);
    check("rd.c2.ready", 32'(req_ready_o), 32'h0);
    tick(); drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("rd.c3.ready", 32'(req_ready_o), 32'h0);
    tick(); drive(2'b00, 2'b00, 1'b0, 1'b1, 32'hDEAD_BEEF); @(negedge clk_i);
    check("rd.c4.rsp", 32'(rsp_valid_o), 32'h0);
    tick(); drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("rd.c5.rsp", 32'(rsp_valid_o), 32'h1);
    check("rd.c5.rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    check("rd.c5.grant", 32'(grant_o), 32'h0);
    tick(); drive(2'b00, 2'b00, 1'b0, 1'b1, 32'h1234_5678); @(negedge clk_i);
    check("idle_rv.c6.rsp", 32'(rsp_valid_o), 32'h0);
    tick(); drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("idle_rv.c7.rsp", 32'(rsp_valid_o), 32'h0);
    check("idle_rv.c7.rdata", rsp_rdata_o, 32'hDEAD_BEEF);
    check("idle_rv.c7.mv", 32'(mem_valid_o), 32'h0);

    // Stalled write issue with req1 waiting, and a stray rvalid mid-issue.
    req_addr_i = {32'h0000_2000, 32'h0000_1000};
    do_reset();
    tick(); drive(2'b01, 2'b11, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("st.c0.ready", 32'(req_ready_o), 32'h1);
    for (int c = 1; c <= 3; c++) begin
      tick(); drive(2'b10, 2'b11, 1'b0, (c == 2), 32'h5555_5555); @(negedge clk_i);
      check($sformatf("st.c%0d.mv", c), 32'(mem_valid_o), 32'h1);
      check($sformatf("st.c%0d.maddr", c), mem_addr_o, 32'h1000);
      check($sformatf("st.c%0d.mwdata", c), mem_wdata_o, 32'hA0);
      check($sformatf("st.c%0d.mwe", c), 32'(mem_we_o), 32'h1);
      check($sformatf("st.c%0d.ready", c), 32'(req_ready_o), 32'h0);
      check($sformatf("st.c%0d.rsp", c), 32'(rsp_valid_o), 32'h0);
      check($sformatf("st.c%0d.grant", c), 32'(grant_o), 32'h1);
    end
    tick(); drive(2'b10, 2'b11, 1'b1, 1'b0, 32'h0); @(negedge clk_i);
    check("st.c4.mv", 32'(mem_valid_o), 32'h1);
    check("st.c4.ready", 32'(req_ready_o), 32'h0);
    tick(); drive(2'b10, 2'b11, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("st.c5.rsp", 32'(rsp_valid_o), 32'h1);
    check("st.c5.mv", 32'(mem_valid_o), 32'h0);
    check("st.c5.ready", 32'(req_ready_o), 32'h2);
    tick(); drive(2'b00, 2'b11, 1'b1, 1'b0, 32'h0); @(negedge clk_i);
    check("st.c6.grant", 32'(grant_o), 32'h2);
    check("st.c6.maddr", mem_addr_o, 32'h2000);
    check("st.c6.mwdata", mem_wdata_o, 32'hB1);
    tick(); drive(2'b00, 2'b11, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("st.c7.rsp", 32'(rsp_valid_o), 32'h2);

    // Reset during WAIT_RSP: outputs clear at once, late rvalid is dropped,
    // credit restarts at w0=2 so req0 wins twice before req1.
    do_reset();
    tick(); drive(2'b01, 2'b00, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("rr.c0.ready", 32'(req_ready_o), 32'h1);
    tick(); drive(2'b00, 2'b00, 1'b1, 1'b0, 32'h0); @(negedge clk_i);
    check("rr.c1.mv", 32'(mem_valid_o), 32'h1);
    tick(); drive(2'b00, 2'b00, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("rr.c2.grant", 32'(grant_o), 32'h1);
    tick(); rst_i = 1'b1; #1;
    check_all_zero("rr.c3");
    tick(); rst_i = 1'b0; drive(2'b00, 2'b00, 1'b0, 1'b1, 32'hCAFE_F00D); @(negedge clk_i);
    check("rr.c4.rsp", 32'(rsp_valid_o), 32'h0);
    tick(); drive(2'b11, 2'b11, 1'b0, 1'b0, 32'h0); @(negedge clk_i);
    check("rr.c5.rsp", 32'(rsp_valid_o), 32'h0);
    check("rr.c5.rdata", rsp_rdata_o, 32'h0);
    check("rr.c5.ready", 32'(req_ready_o), 32'h1);
    tick(); drive(2'b11, 2'b11, 1'b1, 1'b0, 32'h0); @(negedge clk_i);
    check("rr.c6.grant", 32'(grant_o), 32'h1);
    check("rr.c6.ready", 32'(req_ready_o), 32'h0);
    tick(); drive(2'b11, 2'b11, 1'b1, 1'b0, 32'h0); @(negedge clk_i);
    check("rr.c7.ready", 32'(req_ready_o), 32'h1);
    check("rr.c7.rsp", 32'(rsp_valid_o), 32'h1);
    tick(); drive(2'b11, 2'b11, 1'b1, 1'b0, 32'h0); @(negedge clk_i);
    check("rr.c8.grant", 32'(grant_o), 32'h1);
    tick(); drive(2'b11, 2'b11, 1'b1, 1'b0, 32'h0); @(negedge clk_i);
    check("rr.c9.ready", 32'(req_ready_o), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
